// File: rtl/ifmap_wadr_gen_pkg.sv
// Shared types and constants for the ifmap write address generator.
// Field offsets index config_data in units of BANK_ADDR_WIDTH.
package ifmap_wadr_gen_pkg;

  localparam int DEF_BANK_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam int IX0_FIELD = 2;
  localparam int IY0_FIELD = 1;
  localparam int IC1_FIELD = 0;

  localparam logic [1:0] FREE_CNT_MAX = 2'd2;

endpackage

// File: rtl/ifmap_wadr_gen_if.sv
// Write-side stream and SRAM port bundle of the ifmap write address generator.
// master = generator side, slave = upstream/SRAM/reader side.
interface ifmap_wadr_gen_if
  import ifmap_wadr_gen_pkg::*;
#(
  parameter int W = DEF_BANK_ADDR_WIDTH
) ();

  logic         in_valid;
  logic         in_ready;
  logic         wen;
  logic [W-1:0] wadr;
  logic         wbank;
  logic         rd_release;
  logic         block_done;
  logic         done_bank;

  modport master (
    input  in_valid, rd_release,
    output in_ready, wen, wadr, wbank, block_done, done_bank
  );

  modport slave (
    output in_valid, rd_release,
    input  in_ready, wen, wadr, wbank, block_done, done_bank
  );

endinterface

// File: rtl/ifmap_wadr_nest_cnt.sv
// Three-level nested counter (ix fastest, then iy, then ic) with a running
// linear address; everything clears when a step lands on the last position.
module ifmap_wadr_nest_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         step,
  input  logic [W-1:0] ix_max,
  input  logic [W-1:0] iy_max,
  input  logic [W-1:0] ic_max,
  output logic [W-1:0] adr,
  output logic         last
);

  logic [W-1:0] ix, iy, ic;
  logic         ix_wrap, iy_wrap;

  assign ix_wrap = (ix == ix_max);
  assign iy_wrap = (iy == iy_max);
  assign last    = ix_wrap && iy_wrap && (ic == ic_max);

  // The linear address replaces ix + iy*IX0 + ic*IX0*IY0 without multipliers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ix  <= '0;
      iy  <= '0;
      ic  <= '0;
      adr <= '0;
    end else if (clear || (step && last)) begin
      ix  <= '0;
      iy  <= '0;
      ic  <= '0;
      adr <= '0;
    end else if (step) begin
      adr <= adr + W'(1);
      if (ix_wrap) begin
        ix <= '0;
        if (iy_wrap) begin
          iy <= '0;
          ic <= ic + W'(1);
        end else begin
          iy <= iy + W'(1);
        end
      end else begin
        ix <= ix + W'(1);
      end
    end
  end

endmodule

// File: rtl/ifmap_wadr_gen.sv
// Ifmap SRAM write address generator with two-buffer credit and bank toggle.
// Optional macro IFMAP_WADR_STALL_CNT_EN adds a saturating STALL cycle counter.
module ifmap_wadr_gen
  import ifmap_wadr_gen_pkg::*;
#(
  parameter int BANK_ADDR_WIDTH = DEF_BANK_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         config_en,
  input  logic [3*BANK_ADDR_WIDTH-1:0] config_data,
  ifmap_wadr_gen_if.master             bus
`ifdef IFMAP_WADR_STALL_CNT_EN
  ,
  output logic [15:0]                  stall_cnt
`endif
);

  localparam int W = BANK_ADDR_WIDTH;

  state_t       state, state_next;
  logic [1:0]   free_cnt, free_next;
  logic [W-1:0] ix_max, iy_max, ic_max;
  logic         fire, last, last_fire;

  // A zero dimension behaves as one, so its maximum index is also zero.
  function automatic logic [W-1:0] field_max(input logic [W-1:0] f);
    return (f == '0) ? '0 : f - W'(1);
  endfunction

  assign bus.in_ready = (state == WRITE) && !config_en;
  assign fire         = bus.in_valid && bus.in_ready;
  assign bus.wen      = fire;
  assign last_fire    = fire && last;

  ifmap_wadr_nest_cnt #(.W(W)) u_nest_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (config_en),
    .step   (fire),
    .ix_max (ix_max),
    .iy_max (iy_max),
    .ic_max (ic_max),
    .adr    (bus.wadr),
    .last   (last)
  );

  // A completing block and a release in the same cycle cancel out.
  always_comb begin
    free_next = free_cnt;
    if (config_en)
      free_next = FREE_CNT_MAX;
    else if (last_fire && !bus.rd_release)
      free_next = free_cnt - 2'd1;
    else if (!last_fire && bus.rd_release && (free_cnt != FREE_CNT_MAX))
      free_next = free_cnt + 2'd1;
  end

  always_comb begin
    state_next = state;
    if (config_en) begin
      state_next = WRITE;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        WRITE:   if (last_fire && (free_next == 2'd0)) state_next = STALL;
        STALL:   if (free_next != 2'd0) state_next = WRITE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      free_cnt       <= FREE_CNT_MAX;
      ix_max         <= '0;
      iy_max         <= '0;
      ic_max         <= '0;
      bus.wbank      <= 1'b0;
      bus.block_done <= 1'b0;
      bus.done_bank  <= 1'b0;
    end else begin
      state          <= state_next;
      free_cnt       <= free_next;
      bus.block_done <= last_fire;
      if (last_fire)
        bus.done_bank <= bus.wbank;
      if (config_en) begin
        ix_max    <= field_max(config_data[IX0_FIELD*W +: W]);
        iy_max    <= field_max(config_data[IY0_FIELD*W +: W]);
        ic_max    <= field_max(config_data[IC1_FIELD*W +: W]);
        bus.wbank <= 1'b0;
      end else if (last_fire) begin
        bus.wbank <= ~bus.wbank;
      end
    end
  end

`ifdef IFMAP_WADR_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (config_en)
      stall_cnt <= '0;
    else if ((state == STALL) && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ifmap_wadr_gen.sv
// Directed testbench for ifmap_wadr_gen; inputs change and outputs are sampled
// 1 ns after the falling edge. Define IFMAP_WADR_STALL_CNT_EN to cover stall_cnt.
module tb_ifmap_wadr_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        config_en;
  logic [23:0] config_data;
  int          errors = 0;
  int          checks = 0;
`ifdef IFMAP_WADR_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  ifmap_wadr_gen_if #(.W(8)) bus ();

  ifmap_wadr_gen #(.BANK_ADDR_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .config_en   (config_en),
    .config_data (config_data),
    .bus         (bus)
`ifdef IFMAP_WADR_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic valid, input logic release_pulse);
    @(negedge clk);
    config_en      = 1'b0;
    bus.in_valid   = valid;
    bus.rd_release = release_pulse;
    #1;
  endtask

  task automatic do_config(input logic [7:0] ix0, input logic [7:0] iy0,
                           input logic [7:0] ic1, input logic valid);
    @(negedge clk);
    config_en      = 1'b1;
    config_data    = {ix0, iy0, ic1};
    bus.in_valid   = valid;
    bus.rd_release = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; config_en = 1'b0; config_data = '0;
    bus.in_valid = 1'b0; bus.rd_release = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL por_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.wadr !== 8'd0) begin errors++; $display("[TB] FAIL por_wadr got=%0d exp=0", bus.wadr); end
    checks++; if ({bus.wbank, bus.block_done, bus.done_bank, bus.wen} !== 4'b0) begin errors++; $display("[TB] FAIL por_flags got=%b exp=0000", {bus.wbank, bus.block_done, bus.done_bank, bus.wen}); end
    rst_n = 1'b1;
    do_config(8'd5, 8'd5, 8'd2, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0);
      checks++; if (bus.wadr !== 8'(i) || bus.wen !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_wadr i=%0d got=%0d/%b exp=%0d/1", i, bus.wadr, bus.wen, i); end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.wadr !== 8'd0 || bus.in_ready !== 1'b0 || bus.wen !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset got wadr=%0d rdy=%b wen=%b exp 0/0/0", bus.wadr, bus.in_ready, bus.wen); end
    checks++; if ({bus.wbank, bus.block_done, bus.done_bank} !== 3'b0) begin errors++; $display("[TB] FAIL mid_reset_flags got=%b exp=000", {bus.wbank, bus.block_done, bus.done_bank}); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0);
      checks++; if (bus.in_ready !== 1'b0 || bus.wen !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset i=%0d got rdy=%b wen=%b exp 0/0", i, bus.in_ready, bus.wen); end
    end
  endtask

  task automatic test_fill_bank0();
    do_config(8'd5, 8'd5, 8'd2, 1'b1);
    checks++; if (bus.in_ready !== 1'b0 || bus.wen !== 1'b0) begin errors++; $display("[TB] FAIL cfg_blocks_fire got rdy=%b wen=%b exp 0/0", bus.in_ready, bus.wen); end
    for (int i = 0; i < 50; i++) begin
      drive(1'b1, 1'b0);
      checks++; if (bus.wen !== 1'b1 || bus.wadr !== 8'(i) || bus.wbank !== 1'b0 || bus.block_done !== 1'b0) begin errors++; $display("[TB] FAIL bank0_write i=%0d got wen=%b wadr=%0d bank=%b done=%b exp 1/%0d/0/0", i, bus.wen, bus.wadr, bus.wbank, bus.block_done, i); end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 50; i++) begin
      drive(1'b1, 1'b0);
      checks++; if (bus.wadr !== 8'(i) || bus.wbank !== 1'b1 || bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bank1_write i=%0d got wadr=%0d bank=%b rdy=%b exp %0d/1/1", i, bus.wadr, bus.wbank, bus.in_ready, i); end
      if (i < 2) begin
        checks++; if (bus.block_done !== (i == 0) || bus.done_bank !== 1'b0) begin errors++; $display("[TB] FAIL bank0_done i=%0d got done=%b dbank=%b exp %b/0", i, bus.block_done, bus.done_bank, i == 0); end
      end
    end
    drive(1'b1, 1'b0);
    checks++; if (bus.in_ready !== 1'b0 || bus.wen !== 1'b0) begin errors++; $display("[TB] FAIL stall_entry got rdy=%b wen=%b exp 0/0", bus.in_ready, bus.wen); end
    checks++; if (bus.block_done !== 1'b1 || bus.done_bank !== 1'b1) begin errors++; $display("[TB] FAIL bank1_done got done=%b dbank=%b exp 1/1", bus.block_done, bus.done_bank); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold i=%0d got rdy=%b exp 0", i, bus.in_ready); end
    end
    drive(1'b1, 1'b1);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL release_cycle got rdy=%b exp 0", bus.in_ready); end
    drive(1'b1, 1'b0);
    checks++; if (bus.in_ready !== 1'b1 || bus.wadr !== 8'd0 || bus.wbank !== 1'b0) begin errors++; $display("[TB] FAIL stall_exit got rdy=%b wadr=%0d bank=%b exp 1/0/0", bus.in_ready, bus.wadr, bus.wbank); end
  endtask

  // Starts where test_stall left off: bank 0, address 0 presented, one free buffer.
  task automatic test_release_on_last();
    for (int i = 1; i < 50; i++) begin
      drive(1'b1, i == 10);
      checks++; if (bus.wadr !== 8'(i) || bus.wbank !== 1'b0) begin errors++; $display("[TB] FAIL b0_pre_sim i=%0d got wadr=%0d bank=%b exp %0d/0", i, bus.wadr, bus.wbank, i); end
    end
    for (int i = 0; i < 50; i++) begin
      drive(1'b1, i == 49);
      checks++; if (bus.wadr !== 8'(i) || bus.wbank !== 1'b1 || bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b1_sim i=%0d got wadr=%0d bank=%b rdy=%b exp %0d/1/1", i, bus.wadr, bus.wbank, bus.in_ready, i); end
    end
    drive(1'b1, 1'b0);
    checks++; if (bus.in_ready !== 1'b1 || bus.wadr !== 8'd0 || bus.wbank !== 1'b0) begin errors++; $display("[TB] FAIL sim_no_stall got rdy=%b wadr=%0d bank=%b exp 1/0/0", bus.in_ready, bus.wadr, bus.wbank); end
    checks++; if (bus.block_done !== 1'b1 || bus.done_bank !== 1'b1) begin errors++; $display("[TB] FAIL sim_done got done=%b dbank=%b exp 1/1", bus.block_done, bus.done_bank); end
    for (int i = 1; i < 50; i++) begin
      drive(1'b1, (i == 1) || (i == 2));
      checks++; if (bus.wadr !== 8'(i) || bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b0_extra_rel i=%0d got wadr=%0d rdy=%b exp %0d/1", i, bus.wadr, bus.in_ready, i); end
    end
    for (int i = 0; i < 50; i++) begin
      drive(1'b1, 1'b0);
      checks++; if (bus.wadr !== 8'(i) || bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b1_extra_rel i=%0d got wadr=%0d rdy=%b exp %0d/1", i, bus.wadr, bus.in_ready, i); end
    end
    drive(1'b1, 1'b0);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL saturate_stall got rdy=%b exp 0", bus.in_ready); end
  endtask

  task automatic test_toggle_and_reconfig();
    do_config(8'd3, 8'd2, 8'd1, 1'b0);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL cfg2_rdy got=%b exp 0", bus.in_ready); end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0);
      checks++; if (bus.wadr !== 8'(i) || bus.wbank !== 1'b0) begin errors++; $display("[TB] FAIL small_b0 i=%0d got wadr=%0d bank=%b exp %0d/0", i, bus.wadr, bus.wbank, i); end
    end
    for (int k = 0; k < 8; k++) begin
      drive(k % 2 == 0, 1'b0);
      checks++; if (bus.wen !== (k % 2 == 0) || bus.wadr !== 8'((k + 1) / 2) || bus.wbank !== 1'b1) begin errors++; $display("[TB] FAIL toggle k=%0d got wen=%b wadr=%0d bank=%b exp %b/%0d/1", k, bus.wen, bus.wadr, bus.wbank, k % 2 == 0, (k + 1) / 2); end
    end
    do_config(8'd3, 8'd2, 8'd1, 1'b1);
    checks++; if (bus.wen !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reconfig_wins got wen=%b rdy=%b exp 0/0", bus.wen, bus.in_ready); end
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0);
      checks++; if (bus.wadr !== 8'(i % 6) || bus.wbank !== (i >= 6) || bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reconfig_blk i=%0d got wadr=%0d bank=%b rdy=%b exp %0d/%b/1", i, bus.wadr, bus.wbank, bus.in_ready, i % 6, i >= 6); end
    end
    drive(1'b1, 1'b0);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reconfig_stall got rdy=%b exp 0", bus.in_ready); end
  endtask

  task automatic test_zero_field();
    do_config(8'd0, 8'd0, 8'd0, 1'b0);
    drive(1'b1, 1'b0);
    checks++; if (bus.wen !== 1'b1 || bus.wadr !== 8'd0 || bus.wbank !== 1'b0) begin errors++; $display("[TB] FAIL zero_first got wen=%b wadr=%0d bank=%b exp 1/0/0", bus.wen, bus.wadr, bus.wbank); end
    drive(1'b1, 1'b0);
    checks++; if (bus.wen !== 1'b1 || bus.wadr !== 8'd0 || bus.wbank !== 1'b1 || bus.block_done !== 1'b1 || bus.done_bank !== 1'b0) begin errors++; $display("[TB] FAIL zero_second got wen=%b wadr=%0d bank=%b done=%b dbank=%b exp 1/0/1/1/0", bus.wen, bus.wadr, bus.wbank, bus.block_done, bus.done_bank); end
    drive(1'b1, 1'b0);
    checks++; if (bus.in_ready !== 1'b0 || bus.block_done !== 1'b1 || bus.done_bank !== 1'b1) begin errors++; $display("[TB] FAIL zero_stall got rdy=%b done=%b dbank=%b exp 0/1/1", bus.in_ready, bus.block_done, bus.done_bank); end
    drive(1'b0, 1'b0);
    checks++; if (bus.block_done !== 1'b0) begin errors++; $display("[TB] FAIL done_pulse_width got=%b exp 0", bus.block_done); end
  endtask

`ifdef IFMAP_WADR_STALL_CNT_EN
  // Entered with the generator just stalled for two cycles.
  task automatic test_stall_cnt();
    do_config(8'd1, 8'd1, 8'd1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL stall_cnt_start got=%0d exp 0", stall_cnt); end
    repeat (12) drive(1'b0, 1'b0);
    checks++; if (stall_cnt !== 16'd12) begin errors++; $display("[TB] FAIL stall_cnt_12 got=%0d exp 12", stall_cnt); end
    do_config(8'd1, 8'd1, 8'd1, 1'b0);
    drive(1'b0, 1'b0);
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL stall_cnt_clear got=%0d exp 0", stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_bank0();
    test_stall();
    test_release_on_last();
    test_toggle_and_reconfig();
    test_zero_field();
`ifdef IFMAP_WADR_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
